// File: rtl/vend_controller_pkg.sv
// Shared definitions for the vending transaction sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package vend_controller_pkg;

  typedef enum logic [1:0] {
    ST_SELECT  = 2'd0,
    ST_PAYMENT = 2'd1,
    ST_VEND    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] COIN_DOLLAR  = 8'd100;
  localparam logic [7:0] COIN_QUARTER = 8'd25;
  localparam logic [7:0] COIN_DIME    = 8'd10;
  localparam logic [7:0] COIN_NICKEL  = 8'd5;

  // Worst-case price total is 1510, so 11 bits always suffice.
  localparam int PRICE_W = 11;
  localparam logic [PRICE_W-1:0] PRICE [8] = '{
    11'd150, 11'd125, 11'd240, 11'd300, 11'd175, 11'd195, 11'd100, 11'd225
  };

  // Sum of item prices for every selected switch.
  function automatic logic [PRICE_W-1:0] price_sum(input logic [7:0] sel);
    logic [PRICE_W-1:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) s = s + PRICE[i];
    end
    return s;
  endfunction

  // LED pattern {select, payment, vend} for a state; DONE lights nothing.
  function automatic logic [2:0] led_decode(input state_t st);
    logic [2:0] l;
    case (st)
      ST_SELECT:  l = 3'b100;
      ST_PAYMENT: l = 3'b010;
      ST_VEND:    l = 3'b001;
      default:    l = 3'b000;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Button/switch inputs and display-side outputs of the transaction sequencer.
// Latency: none (wiring only).
// Backpressure: none; inputs are sampled every cycle, outputs are level signals.
interface vend_controller_if #(
  parameter int AW = 12
);
  logic          dollar;
  logic          quarter;
  logic          dime;
  logic          nickel;
  logic          credit;
  logic          cancel;
  logic [7:0]    sw;
  logic          select_led;
  logic          payment_led;
  logic          vend_led;
  logic [AW-1:0] total_due;
  logic [AW-1:0] paid;
  logic [AW-1:0] remaining;
  logic [AW-1:0] change;
  logic          change_vld;

  modport master (
    output dollar, quarter, dime, nickel, credit, cancel, sw,
    input  select_led, payment_led, vend_led, total_due, paid, remaining, change, change_vld
  );

  modport slave (
    input  dollar, quarter, dime, nickel, credit, cancel, sw,
    output select_led, payment_led, vend_led, total_due, paid, remaining, change, change_vld
  );
endinterface

// File: rtl/vend_controller_btn_rise.sv
// One-bit rising-edge detector for a button input.
// Latency: combinational pulse in the cycle the input first reads high.
// Backpressure: none; a held input yields a single pulse.
module vend_controller_btn_rise (
  input  logic clk_fast,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  // Remember last cycle's level so only the 0->1 transition is reported.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: SELECT -> PAYMENT -> VEND -> DONE with coin accounting.
// Latency: a coin/credit/cancel edge updates amounts and state on that same clock edge.
// Backpressure: none; edges arriving while they are not accepted are dropped.
module vend_controller
  import vend_controller_pkg::*;
#(
  parameter int AW          = 12,
  parameter int VEND_CYCLES = 100000000
) (
  input  logic            clk_fast,
  input  logic            rst,
  vend_controller_if.slave bus
);
  localparam int CW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [CW-1:0] VEND_LAST = CW'(VEND_CYCLES - 1);

  logic dollar_rise, quarter_rise, dime_rise, nickel_rise, credit_rise, cancel_rise;

  vend_controller_btn_rise u_dollar  (.clk_fast(clk_fast), .rst(rst), .d(bus.dollar),  .rise(dollar_rise));
  vend_controller_btn_rise u_quarter (.clk_fast(clk_fast), .rst(rst), .d(bus.quarter), .rise(quarter_rise));
  vend_controller_btn_rise u_dime    (.clk_fast(clk_fast), .rst(rst), .d(bus.dime),    .rise(dime_rise));
  vend_controller_btn_rise u_nickel  (.clk_fast(clk_fast), .rst(rst), .d(bus.nickel),  .rise(nickel_rise));
  vend_controller_btn_rise u_credit  (.clk_fast(clk_fast), .rst(rst), .d(bus.credit),  .rise(credit_rise));
  vend_controller_btn_rise u_cancel  (.clk_fast(clk_fast), .rst(rst), .d(bus.cancel),  .rise(cancel_rise));

  state_t        state;
  logic [2:0]    leds_q;
  logic [AW-1:0] paid_q, change_q, total_q;
  logic          change_vld_q;
  logic [CW-1:0] vend_cnt;

  logic [AW-1:0] price;
  logic [7:0]    coin_sum;
  logic [AW-1:0] coin_val;
  logic          coin_any;
  logic          sw_any;
  logic [AW:0]   paid_wide;
  logic [AW-1:0] paid_add;

  assign price    = AW'(price_sum(bus.sw));
  assign sw_any   = |bus.sw;
  assign coin_any = dollar_rise | quarter_rise | dime_rise | nickel_rise;
  // Simultaneous coin edges add together; max 140 fits in 8 bits.
  assign coin_sum = (dollar_rise  ? COIN_DOLLAR  : 8'd0) +
                    (quarter_rise ? COIN_QUARTER : 8'd0) +
                    (dime_rise    ? COIN_DIME    : 8'd0) +
                    (nickel_rise  ? COIN_NICKEL  : 8'd0);
  assign coin_val  = AW'(coin_sum);
  // Running total saturates rather than wrapping.
  assign paid_wide = {1'b0, paid_q} + {1'b0, coin_val};
  assign paid_add  = paid_wide[AW] ? '1 : paid_wide[AW-1:0];

  // Transaction FSM; LED pattern is registered alongside each state change.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state        <= ST_SELECT;
      leds_q       <= led_decode(ST_SELECT);
      paid_q       <= '0;
      change_q     <= '0;
      total_q      <= '0;
      change_vld_q <= 1'b0;
      vend_cnt     <= '0;
    end else begin
      change_vld_q <= 1'b0;
      case (state)
        ST_SELECT: begin
          if (sw_any && credit_rise) begin
            total_q  <= price;
            paid_q   <= '0;
            change_q <= '0;
            state    <= ST_VEND;
            leds_q   <= led_decode(ST_VEND);
          end else if (sw_any && coin_any) begin
            total_q <= price;
            paid_q  <= coin_val;
            if (coin_val >= price) begin
              change_q <= coin_val - price;
              state    <= ST_VEND;
              leds_q   <= led_decode(ST_VEND);
            end else begin
              state    <= ST_PAYMENT;
              leds_q   <= led_decode(ST_PAYMENT);
            end
          end
        end
        ST_PAYMENT: begin
          if (cancel_rise) begin
            change_q     <= paid_q;
            change_vld_q <= 1'b1;
            state        <= ST_DONE;
            leds_q       <= led_decode(ST_DONE);
          end else if (credit_rise) begin
            change_q <= paid_q;
            state    <= ST_VEND;
            leds_q   <= led_decode(ST_VEND);
          end else if (coin_any) begin
            paid_q <= paid_add;
            if (paid_add >= total_q) begin
              change_q <= paid_add - total_q;
              state    <= ST_VEND;
              leds_q   <= led_decode(ST_VEND);
            end
          end
        end
        ST_VEND: begin
          if (vend_cnt == VEND_LAST) begin
            vend_cnt     <= '0;
            change_vld_q <= 1'b1;
            state        <= ST_DONE;
            leds_q       <= led_decode(ST_DONE);
          end else begin
            vend_cnt <= vend_cnt + CW'(1);
          end
        end
        default: begin
          if (!sw_any) begin
            paid_q   <= '0;
            change_q <= '0;
            total_q  <= '0;
            state    <= ST_SELECT;
            leds_q   <= led_decode(ST_SELECT);
          end
        end
      endcase
    end
  end

  assign bus.select_led  = leds_q[2];
  assign bus.payment_led = leds_q[1];
  assign bus.vend_led    = leds_q[0];
  assign bus.total_due   = (state == ST_SELECT) ? price : total_q;
  assign bus.paid        = paid_q;
  assign bus.remaining   = (bus.total_due > paid_q) ? (bus.total_due - paid_q) : '0;
  assign bus.change      = change_q;
  assign bus.change_vld  = change_vld_q;
endmodule

// File: tb/tb_vend_controller.sv
`timescale 1ns/1ps
module tb_vend_controller;
  logic clk_fast;
  logic rst;
  int   checks;
  int   failures;

  vend_controller_if #(.AW(12)) bus ();

  vend_controller #(.AW(12), .VEND_CYCLES(8)) dut (
    .clk_fast(clk_fast),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk_fast = 1'b0;
  always #1 clk_fast = ~clk_fast;

  task automatic step();
    @(negedge clk_fast);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [5:0] m);
    {bus.dollar, bus.quarter, bus.dime, bus.nickel, bus.credit, bus.cancel} = m;
  endtask

  // Raise the buttons in m for one edge, then release them for one edge.
  task automatic press(input logic [5:0] m);
    set_btn(m);
    step();
    set_btn(6'b0);
    step();
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.change_vld === 1'b1) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  localparam logic [5:0] B_DOLLAR  = 6'b100000;
  localparam logic [5:0] B_QUARTER = 6'b010000;
  localparam logic [5:0] B_DIME    = 6'b001000;
  localparam logic [5:0] B_NICKEL  = 6'b000100;
  localparam logic [5:0] B_CREDIT  = 6'b000010;
  localparam logic [5:0] B_CANCEL  = 6'b000001;

  initial begin
    logic seen_vld;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.sw   = 8'd0;
    set_btn(6'b0);
    step();
    step();
    chk("rst_select_led", bus.select_led, 1);
    chk("rst_payment_led", bus.payment_led, 0);
    chk("rst_vend_led", bus.vend_led, 0);
    chk("rst_paid", bus.paid, 0);
    chk("rst_total_due", bus.total_due, 0);
    chk("rst_change", bus.change, 0);
    chk("rst_change_vld", bus.change_vld, 0);
    rst = 1'b0;
    step();

    // 1: multi-coin purchase with change
    bus.sw = 8'b0010_1100;
    step();
    chk("t1_live_total", bus.total_due, 735);
    for (int i = 0; i < 7; i++) press(B_DOLLAR);
    chk("t1_paid_700", bus.paid, 700);
    chk("t1_payment_led", bus.payment_led, 1);
    chk("t1_remaining_35", bus.remaining, 35);
    press(B_QUARTER);
    chk("t1_paid_725", bus.paid, 725);
    press(B_NICKEL);
    chk("t1_paid_730", bus.paid, 730);
    bus.dime = 1'b1;
    step();
    bus.dime = 1'b0;
    chk("t1_vend_led", bus.vend_led, 1);
    chk("t1_paid_740", bus.paid, 740);
    chk("t1_change_5", bus.change, 5);
    chk("t1_remaining_0", bus.remaining, 0);
    for (int i = 0; i < 7; i++) step();
    chk("t1_still_vend", bus.vend_led, 1);
    chk("t1_no_vld_yet", bus.change_vld, 0);
    step();
    chk("t1_done_vld", bus.change_vld, 1);
    chk("t1_done_leds", {bus.select_led, bus.payment_led, bus.vend_led}, 0);
    chk("t1_done_change", bus.change, 5);
    step();
    chk("t1_vld_pulse", bus.change_vld, 0);
    chk("t1_hold_done", bus.select_led, 0);
    bus.sw = 8'd0;
    step();
    chk("t1_back_select", bus.select_led, 1);
    chk("t1_clr_paid", bus.paid, 0);
    chk("t1_clr_change", bus.change, 0);

    // 2: held dollar counts once
    bus.sw = 8'b0000_0100;
    bus.dollar = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.dollar = 1'b0;
    step();
    chk("t2_paid_100", bus.paid, 100);
    chk("t2_payment_led", bus.payment_led, 1);
    chk("t2_remaining_140", bus.remaining, 140);
    bus.sw = 8'b0000_1100;
    step();
    chk("t2_sw_ignored", bus.total_due, 240);
    press(B_CANCEL);
    chk("t2_cancel_change", bus.change, 100);
    bus.sw = 8'd0;
    step();

    // 3: coins ignored with no selection; simultaneous coins add
    press(B_DOLLAR);
    chk("t3_select_led", bus.select_led, 1);
    chk("t3_paid_0", bus.paid, 0);
    bus.sw = 8'b0100_0000;
    step();
    chk("t3_live_total", bus.total_due, 100);
    press(B_DOLLAR | B_NICKEL);
    chk("t3_vend_led", bus.vend_led, 1);
    chk("t3_paid_105", bus.paid, 105);
    chk("t3_change_5", bus.change, 5);
    wait_done("t3_done");
    bus.sw = 8'd0;
    step();

    // 4: cancel beats credit; DONE holds until sw clears
    bus.sw = 8'b0000_1000;
    press(B_QUARTER);
    press(B_QUARTER);
    chk("t4_paid_50", bus.paid, 50);
    set_btn(B_CANCEL | B_CREDIT);
    step();
    set_btn(6'b0);
    chk("t4_done_leds", {bus.select_led, bus.payment_led, bus.vend_led}, 0);
    chk("t4_change_50", bus.change, 50);
    chk("t4_vld", bus.change_vld, 1);
    step();
    chk("t4_vld_pulse", bus.change_vld, 0);
    step();
    chk("t4_hold_done", {bus.select_led, bus.payment_led, bus.vend_led}, 0);
    bus.sw = 8'd0;
    step();
    chk("t4_select_led", bus.select_led, 1);
    chk("t4_clr_paid", bus.paid, 0);
    chk("t4_clr_change", bus.change, 0);
    chk("t4_clr_total", bus.total_due, 0);

    // 5: credit refunds coins; coins ignored during VEND
    bus.sw = 8'b0000_0001;
    press(B_DIME);
    chk("t5_paid_10", bus.paid, 10);
    bus.credit = 1'b1;
    step();
    bus.credit = 1'b0;
    chk("t5_vend_led", bus.vend_led, 1);
    chk("t5_change_10", bus.change, 10);
    step();
    press(B_DOLLAR);
    chk("t5_paid_frozen", bus.paid, 10);
    chk("t5_still_vend", bus.vend_led, 1);
    wait_done("t5_done");
    chk("t5_done_change", bus.change, 10);
    bus.sw = 8'd0;
    step();

    // 6: reset mid-PAYMENT discards the transaction
    bus.sw = 8'b0000_1000;
    press(B_DOLLAR | B_QUARTER);
    chk("t6_paid_125", bus.paid, 125);
    chk("t6_payment_led", bus.payment_led, 1);
    rst = 1'b1;
    #0.25;
    chk("t6_async_select", bus.select_led, 1);
    chk("t6_async_paid", bus.paid, 0);
    step();
    rst = 1'b0;
    seen_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.change_vld !== 1'b0) seen_vld = 1'b1;
    end
    chk("t6_no_vld", seen_vld, 0);
    chk("t6_select_led", bus.select_led, 1);
    chk("t6_paid_0", bus.paid, 0);
    chk("t6_live_total", bus.total_due, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
